// File: rtl/disk_req_arbiter_pkg.sv
// Shared definitions for the two-client disk request arbiter.
// Covers command and mailbox bit positions, op encodings and the FSM state type.
package disk_req_arbiter_pkg;

  localparam int CMD_W    = 19;
  localparam int SECTOR_W = 8;
  localparam int TRACK_W  = 7;
  localparam int OP_W     = 2;
  localparam int RESULT_W = 16;
  localparam int TMO_W    = 24;

  localparam logic [OP_W-1:0] OP_READ   = 2'b00;
  localparam logic [OP_W-1:0] OP_WRITE  = 2'b01;
  localparam logic [OP_W-1:0] OP_SEEK   = 2'b10;
  localparam logic [OP_W-1:0] OP_READID = 2'b11;

  // Client command layout: {op, drive, head, track, sector}
  localparam int CMD_SECTOR_LSB = 0;
  localparam int CMD_TRACK_LSB  = 8;
  localparam int CMD_HEAD       = 15;
  localparam int CMD_DRIVE      = 16;
  localparam int CMD_OP_LSB     = 17;

  localparam int SR_SECTOR_LSB = 0;
  localparam int SR_TRACK_LSB  = 8;
  localparam int SR_HEAD       = 15;
  localparam int SR_ACK        = 16;
  localparam int SR_OP_LSB     = 17;
  localparam int SR_DRIVE      = 19;
  localparam int SR_VALID      = 20;
  localparam int SR_CLIENT     = 21;

  localparam int CR_ERR        = 3;
  localparam int CR_DONE       = 4;
  localparam int CR_HEAD_LSB   = 8;
  localparam int CR_SECTOR_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_DONE    = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

  // Mailbox word for a freshly granted command: valid set, ack clear.
  function automatic logic [31:0] pack_sr(input logic [CMD_W-1:0] cmd, input logic client);
    logic [31:0] sr;
    sr = '0;
    sr[SR_SECTOR_LSB +: SECTOR_W] = cmd[CMD_SECTOR_LSB +: SECTOR_W];
    sr[SR_TRACK_LSB +: TRACK_W]   = cmd[CMD_TRACK_LSB +: TRACK_W];
    sr[SR_HEAD]                   = cmd[CMD_HEAD];
    sr[SR_DRIVE]                  = cmd[CMD_DRIVE];
    sr[SR_OP_LSB +: OP_W]         = cmd[CMD_OP_LSB +: OP_W];
    sr[SR_VALID]                  = 1'b1;
    sr[SR_CLIENT]                 = client;
    return sr;
  endfunction

endpackage

// File: rtl/disk_req_arbiter_if.sv
// Client and host signals of the disk request arbiter.
// Handshake: a client holds req (and a stable cmd) until it sees its one-cycle done pulse;
// err/result are meaningful only while done is high.
interface disk_req_arbiter_if;
  import disk_req_arbiter_pkg::*;

  logic                c0_req;
  logic                c1_req;
  logic [CMD_W-1:0]    c0_cmd;
  logic [CMD_W-1:0]    c1_cmd;
  logic                c0_done;
  logic                c1_done;
  logic                c0_err;
  logic                c1_err;
  logic [RESULT_W-1:0] c0_result;
  logic [RESULT_W-1:0] c1_result;
  logic [31:0]         host_sr;
  logic [31:0]         host_cr;
  logic                busy;
  logic                grant;
  state_t              dbg_state;

  modport slave (
    input  c0_req, c1_req, c0_cmd, c1_cmd, host_cr,
    output c0_done, c1_done, c0_err, c1_err, c0_result, c1_result,
    output host_sr, busy, grant, dbg_state
  );

  modport master (
    output c0_req, c1_req, c0_cmd, c1_cmd, host_cr,
    input  c0_done, c1_done, c0_err, c1_err, c0_result, c1_result,
    input  host_sr, busy, grant, dbg_state
  );

endinterface

// File: rtl/disk_req_arbiter.sv
// Round-robin arbiter passing one client command at a time to a host mailbox,
// with stale-done filtering, a saturating reply timeout and done/err/result return.
module disk_req_arbiter
  import disk_req_arbiter_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT = 24'd10_000_000
) (
  input logic              clk,
  input logic              rst_n,
  disk_req_arbiter_if.slave bus
);

  state_t              state, state_nxt;
  logic                last_grant;
  logic                grant_q;
  logic                seen_low;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [31:0]         host_sr_q;
  logic [1:0]          done_q;
  logic [1:0]          err_q;
  logic [RESULT_W-1:0] res0_q;
  logic [RESULT_W-1:0] res1_q;

  logic                cr_done;
  logic                pick;
  logic                do_grant;
  logic                do_complete;
  logic                do_timeout;
  logic                do_release;
  logic [CMD_W-1:0]    sel_cmd;
  logic [RESULT_W-1:0] cpl_result;

  assign cr_done    = bus.host_cr[CR_DONE];
  assign sel_cmd    = pick ? bus.c1_cmd : bus.c0_cmd;
  assign cpl_result = do_complete ?
                      {bus.host_cr[CR_SECTOR_LSB +: 8], bus.host_cr[CR_HEAD_LSB +: 8]} : '0;

  always_comb begin
    state_nxt   = state;
    pick        = 1'b0;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    do_timeout  = 1'b0;
    do_release  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          do_grant  = 1'b1;
          pick      = (bus.c0_req && bus.c1_req) ? ~last_grant : bus.c1_req;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A host reply wins over a timeout expiring in the same cycle.
        if (cr_done && seen_low) begin
          do_complete = 1'b1;
          state_nxt   = ST_WAIT_RELEASE;
        end else if (TIMEOUT != '0 && tmo_cnt == TIMEOUT) begin
          do_timeout = 1'b1;
          state_nxt  = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!cr_done) begin
          do_release = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      seen_low   <= 1'b0;
      tmo_cnt    <= '0;
      host_sr_q  <= '0;
      done_q     <= '0;
      err_q      <= '0;
      res0_q     <= '0;
      res1_q     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      res0_q <= '0;
      res1_q <= '0;
      if (state == ST_WAIT_DONE) begin
        if (!cr_done)        seen_low <= 1'b1;
        if (tmo_cnt != '1)   tmo_cnt  <= tmo_cnt + 1'b1;
      end
      if (do_grant) begin
        host_sr_q  <= pack_sr(sel_cmd, pick);
        grant_q    <= pick;
        last_grant <= pick;
        tmo_cnt    <= '0;
        // A done bit already high at grant belongs to an earlier exchange.
        seen_low   <= ~cr_done;
      end
      if (do_complete || do_timeout) begin
        host_sr_q[SR_VALID] <= 1'b0;
        host_sr_q[SR_ACK]   <= do_complete;
        done_q[grant_q]     <= 1'b1;
        err_q[grant_q]      <= do_timeout | bus.host_cr[CR_ERR];
        if (grant_q) res1_q <= cpl_result;
        else         res0_q <= cpl_result;
      end
      if (do_release) host_sr_q[SR_ACK] <= 1'b0;
    end
  end

  assign bus.c0_done   = done_q[0];
  assign bus.c1_done   = done_q[1];
  assign bus.c0_err    = err_q[0];
  assign bus.c1_err    = err_q[1];
  assign bus.c0_result = res0_q;
  assign bus.c1_result = res1_q;
  assign bus.host_sr   = host_sr_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.grant     = grant_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_disk_req_arbiter.sv
// Directed bench for disk_req_arbiter: round robin, mailbox encoding, error reply,
// timeout, reset abort and stale host done.
module tb_disk_req_arbiter;
  import disk_req_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done0_cnt = 0;
  int   done1_cnt = 0;
  int   overlap_cnt = 0;
  int   stray_cnt = 0;
  logic [0:0] exp_q[$];

  disk_req_arbiter_if bus();

  disk_req_arbiter #(.TIMEOUT(24'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // done pulse bookkeeping
  always @(negedge clk) begin
    if (bus.c0_done) done0_cnt++;
    if (bus.c1_done) done1_cnt++;
    if (bus.c0_done && bus.c1_done) overlap_cnt++;
    if (bus.grant == 1'b0 && (bus.c1_done || bus.c1_err || bus.c1_result != '0)) stray_cnt++;
    if (bus.grant == 1'b1 && (bus.c0_done || bus.c0_err || bus.c0_result != '0)) stray_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serve one transaction with the given host reply; grant is checked against exp_q.
  task automatic serve(input logic [31:0] reply);
    int n;
    logic g;
    logic d;
    logic e;
    logic [15:0] r;
    n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("grant_wait", 32'(n < 20), 1);
    g = bus.grant;
    check("grant_order", g, exp_q.pop_front());
    bus.host_cr = reply;
    n = 0;
    d = 1'b0;
    while (!d && n < 20) begin
      @(negedge clk);
      n++;
      d = g ? bus.c1_done : bus.c0_done;
    end
    check("done_lat", n, 1);
    e = g ? bus.c1_err : bus.c0_err;
    r = g ? bus.c1_result : bus.c0_result;
    check("err", e, reply[3]);
    check("result", r, {reply[31:24], reply[15:8]});
    check("sr_valid_ack", {bus.host_sr[20], bus.host_sr[16]}, 2'b01);
    bus.host_cr = '0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("release_lat", n, 1);
  endtask

  initial begin
    int n;
    int d1;
    logic [31:0] rr_reply[4];
    rr_reply = '{32'hA1003410, 32'hB2004510, 32'hC3005618, 32'hD4006710};

    bus.c0_req = 1'b0;
    bus.c1_req = 1'b0;
    bus.c0_cmd = '0;
    bus.c1_cmd = '0;
    bus.host_cr = '0;
    rst_n = 1'b0;
    tick(3);
    check("rst_sr", bus.host_sr, 32'h0);
    check("rst_busy_grant", {bus.busy, bus.grant}, 2'b00);
    check("rst_done_err", {bus.c0_done, bus.c1_done, bus.c0_err, bus.c1_err}, 4'b0);
    check("rst_results", {bus.c0_result, bus.c1_result}, 32'h0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // round robin from reset: 0,1,0,1
    bus.c0_cmd = {OP_WRITE, 1'b0, 1'b1, 7'd3, 8'h10};
    bus.c1_cmd = {OP_READID, 1'b1, 1'b0, 7'd9, 8'h20};
    bus.c0_req = 1'b1;
    bus.c1_req = 1'b1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      serve(rr_reply[i]);
      if (i < 3) begin
        check("idle_gap", bus.dbg_state, ST_IDLE);
        tick(1);
        check("regrant", bus.busy, 1);
      end else begin
        bus.c0_req = 1'b0;
        bus.c1_req = 1'b0;
      end
    end

    // c0 read track 5 sector C1
    tick(1);
    bus.c0_cmd = {OP_READ, 1'b0, 1'b0, 7'd5, 8'hC1};
    bus.c0_req = 1'b1;
    tick(1);
    check("t1_sr", bus.host_sr, 32'h001005C1);
    check("t1_grant", bus.grant, 0);
    check("t1_state", bus.dbg_state, ST_WAIT_DONE);
    bus.c0_cmd = '1;
    bus.host_cr = 32'hC1000010;
    tick(1);
    check("t1_done", {bus.c0_done, bus.c1_done, bus.c0_err}, 3'b100);
    check("t1_result", bus.c0_result, 16'hC100);
    check("t1_sr_ack", bus.host_sr, 32'h000105C1);
    bus.c0_req = 1'b0;
    tick(1);
    check("t1_done_width", bus.c0_done, 0);
    check("t1_sr_hold", bus.host_sr, 32'h000105C1);
    bus.host_cr = '0;
    tick(1);
    check("t1_sr_rel", bus.host_sr, 32'h000005C1);
    check("t1_idle", {bus.busy, bus.dbg_state}, {1'b0, ST_IDLE});

    // c1 seek with host error
    bus.c1_cmd = {OP_SEEK, 1'b1, 1'b1, 7'h12, 8'h34};
    bus.c1_req = 1'b1;
    tick(1);
    check("t2_sr", bus.host_sr, 32'h003C9234);
    check("t2_grant", bus.grant, 1);
    bus.host_cr = 32'h00000018;
    tick(1);
    check("t2_done", {bus.c1_done, bus.c1_err, bus.c0_done}, 3'b110);
    check("t2_result", bus.c1_result, 16'h0000);
    check("t2_sr_ack", bus.host_sr, 32'h002D9234);
    bus.c1_req = 1'b0;
    tick(2);
    check("t2_ack_hold", {bus.host_sr[16], bus.c1_done}, 2'b10);
    bus.host_cr = '0;
    tick(1);
    check("t2_ack_clr", {bus.host_sr[16], bus.busy}, 2'b00);

    // timeout with no host reply
    bus.c0_cmd = {OP_WRITE, 1'b1, 1'b0, 7'd100, 8'h07};
    bus.c0_req = 1'b1;
    tick(1);
    check("to_busy", bus.busy, 1);
    n = 0;
    while (!bus.c0_done && n < 40) begin tick(1); n++; end
    check("to_latency", n, 17);
    check("to_err", bus.c0_err, 1);
    check("to_result", bus.c0_result, 16'h0000);
    check("to_sr_bits", {bus.host_sr[20], bus.host_sr[16]}, 2'b00);
    bus.c0_req = 1'b0;
    tick(1);
    check("to_idle", {bus.c0_done, bus.dbg_state}, {1'b0, ST_IDLE});

    // reset during WAIT_DONE
    bus.c1_cmd = {OP_READ, 1'b0, 1'b1, 7'd1, 8'h02};
    bus.c1_req = 1'b1;
    tick(1);
    check("rm_busy", bus.busy, 1);
    tick(2);
    d1 = done1_cnt;
    rst_n = 1'b0;
    tick(1);
    check("rm_sr", bus.host_sr, 32'h0);
    check("rm_state", bus.dbg_state, ST_IDLE);
    check("rm_no_done", done1_cnt - d1, 0);
    rst_n = 1'b1;
    exp_q.push_back(1'b1);
    serve(32'h5A00A510);
    bus.c1_req = 1'b0;

    // host done still high at grant is stale
    bus.c0_cmd = {OP_READID, 1'b0, 1'b0, 7'd0, 8'h00};
    bus.host_cr = 32'h00000010;
    bus.c0_req = 1'b1;
    tick(1);
    check("st_state", bus.dbg_state, ST_WAIT_DONE);
    tick(5);
    check("st_hold", {bus.c0_done, bus.dbg_state}, {1'b0, ST_WAIT_DONE});
    bus.host_cr = '0;
    tick(1);
    check("st_low", {bus.c0_done, bus.dbg_state}, {1'b0, ST_WAIT_DONE});
    bus.host_cr = 32'h77003310;
    tick(1);
    check("st_done", {bus.c0_done, bus.c0_err}, 2'b10);
    check("st_result", bus.c0_result, 16'h7733);
    bus.c0_req = 1'b0;
    bus.host_cr = '0;
    tick(1);
    check("st_idle", bus.dbg_state, ST_IDLE);

    // final report
    tick(3);
    check("c0_done_total", done0_cnt, 5);
    check("c1_done_total", done1_cnt, 4);
    check("done_overlap", overlap_cnt, 0);
    check("stray_outputs", stray_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
